// File: rtl/multi_commit_storebuffer.sv
// ---------------------------------------------------------------------------
// multi_commit_storebuffer
//
// Circular store buffer sitting between a pipeline and memory. Stores are
// allocated speculatively at head, retired in order by the commit pointer
// (up to COMMIT_W per cycle), and drained to memory from tail once committed.
// A flush throws away everything still uncommitted but keeps committed
// stores, since those are architecturally done and must reach memory.
//
// Optional feature macro: SB_STORE_FWD_EN
//   defined   -> byte-granular load forwarding from all valid entries
//   undefined -> fwd_* outputs tied to 0, no comparators built
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   flush_i             pipeline flush
//   push_valid_i/ready  store-allocate handshake
//   push_addr/data/strb store payload
//   commit_cnt_i        number of oldest uncommitted stores retired this cycle
//   out_valid/ready     drain handshake to memory
//   out_addr/data/strb  oldest committed entry (combinational from tail)
//   sb_cnt_o/empty_o    registered occupancy
//   fwd_addr_i          load address to forward for
//   fwd_hit/data/strb   forwarding result
// ---------------------------------------------------------------------------
module multi_commit_storebuffer #(
    parameter int SB_SIZE  = 8,
    parameter int COMMIT_W = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [ADDR_W-1:0]             push_addr_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic [DATA_W/8-1:0]           push_strb_i,
    input  logic [$clog2(COMMIT_W+1)-1:0] commit_cnt_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ADDR_W-1:0]             out_addr_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [DATA_W/8-1:0]           out_strb_o,
    output logic [$clog2(SB_SIZE+1)-1:0]  sb_cnt_o,
    output logic                          sb_empty_o,
    input  logic [ADDR_W-1:0]             fwd_addr_i,
    output logic                          fwd_hit_o,
    output logic [DATA_W-1:0]             fwd_data_o,
    output logic [DATA_W/8-1:0]           fwd_strb_o
);

    localparam int PW = $clog2(SB_SIZE);
    localparam int CW = $clog2(SB_SIZE + 1);
    localparam int SW = DATA_W / 8;

    // Entry storage. Payload needs no reset: it is only observed through
    // valid/committed state, which is reset.
    logic [ADDR_W-1:0] addr_q [SB_SIZE];
    logic [DATA_W-1:0] data_q [SB_SIZE];
    logic [SW-1:0]     strb_q [SB_SIZE];
    logic [SB_SIZE-1:0] valid_q, valid_n;

    logic [PW-1:0] head_q, head_n;
    logic [PW-1:0] cmt_ptr_q, cmt_ptr_n;
    logic [PW-1:0] tail_q, tail_n;
    logic [CW-1:0] total_q, total_n;
    logic [CW-1:0] cmt_cnt_q, cmt_cnt_n;

    logic [CW-1:0] unc_cnt;
    logic [CW-1:0] commit_req;
    logic [CW-1:0] commit_n;
    logic [CW-1:0] discard_cnt;
    logic [PW-1:0] flush_off;
    logic          push_fire;
    logic          drain_fire;

    assign push_ready_o = (total_q < CW'(SB_SIZE));
    assign out_valid_o  = (cmt_cnt_q != '0);
    assign out_addr_o   = addr_q[tail_q];
    assign out_data_o   = data_q[tail_q];
    assign out_strb_o   = strb_q[tail_q];
    assign sb_cnt_o     = total_q;
    assign sb_empty_o   = (total_q == '0);

    assign push_fire  = push_valid_i & push_ready_o & ~flush_i;
    assign drain_fire = out_valid_o & out_ready_i;

    always_comb begin
        unc_cnt     = total_q - cmt_cnt_q;
        commit_req  = CW'(commit_cnt_i);
        // Commit works on the registered uncommitted count, so a store pushed
        // this cycle cannot be retired until the next one.
        commit_n    = (commit_req < unc_cnt) ? commit_req : unc_cnt;
        discard_cnt = unc_cnt - commit_n;

        cmt_ptr_n = cmt_ptr_q + PW'(commit_n);
        cmt_cnt_n = cmt_cnt_q + commit_n - CW'(drain_fire);
        tail_n    = tail_q + PW'(drain_fire);

        if (flush_i) begin
            // Uncommitted entries vanish: head snaps back to the commit point.
            head_n  = cmt_ptr_n;
            total_n = cmt_cnt_n;
        end else begin
            head_n  = head_q + PW'(push_fire);
            total_n = total_q + CW'(push_fire) - CW'(drain_fire);
        end

        valid_n   = valid_q;
        flush_off = '0;
        for (int i = 0; i < SB_SIZE; i++) begin
            // Distance from the post-commit pointer; anything closer than
            // the discard count is an uncommitted entry being flushed.
            flush_off = PW'(i) - cmt_ptr_n;
            if (flush_i && (CW'(flush_off) < discard_cnt)) begin
                valid_n[i] = 1'b0;
            end
        end
        if (drain_fire) begin
            valid_n[tail_q] = 1'b0;
        end
        if (push_fire) begin
            valid_n[head_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            cmt_ptr_q <= '0;
            tail_q    <= '0;
            total_q   <= '0;
            cmt_cnt_q <= '0;
            valid_q   <= '0;
        end else begin
            head_q    <= head_n;
            cmt_ptr_q <= cmt_ptr_n;
            tail_q    <= tail_n;
            total_q   <= total_n;
            cmt_cnt_q <= cmt_cnt_n;
            valid_q   <= valid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_q[head_q] <= push_addr_i;
            data_q[head_q] <= push_data_i;
            strb_q[head_q] <= push_strb_i;
        end
    end

`ifdef SB_STORE_FWD_EN
    localparam int OB = $clog2(SW);

    logic [PW-1:0] fwd_idx;

    // Walk from oldest (tail) to youngest so later matches overwrite earlier
    // ones byte by byte; the youngest writer of each byte wins.
    always_comb begin
        fwd_data_o = '0;
        fwd_strb_o = '0;
        fwd_idx    = '0;
        for (int k = 0; k < SB_SIZE; k++) begin
            fwd_idx = tail_q + PW'(k);
            if (valid_q[fwd_idx] &&
                (addr_q[fwd_idx][ADDR_W-1:OB] == fwd_addr_i[ADDR_W-1:OB])) begin
                for (int b = 0; b < SW; b++) begin
                    if (strb_q[fwd_idx][b]) begin
                        fwd_data_o[b*8 +: 8] = data_q[fwd_idx][b*8 +: 8];
                        fwd_strb_o[b]        = 1'b1;
                    end
                end
            end
        end
        fwd_hit_o = (fwd_strb_o != '0);
    end
`else
    logic unused_fwd;

    // Without forwarding, the load address and per-entry valid bits have no
    // reader; fold them into one sink so nothing looks accidentally dangling.
    assign unused_fwd = ^{fwd_addr_i, valid_q};
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = '0;
    assign fwd_strb_o = '0;
`endif

endmodule
